// File: rtl/count_job_sched_pkg.sv
// Shared definitions for the round-robin counter job scheduler.
package count_job_sched_pkg;

  // Default sizing: requesters, counter width, job length width.
  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 3;
  localparam int LW_DEF   = 4;

  // Scheduler FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter control priority at a clock edge: lower value wins.
  // clear beats preset, preset beats start (increment mod 2^W).
  localparam int CTRL_PRIO_CLEAR  = 0;
  localparam int CTRL_PRIO_PRESET = 1;
  localparam int CTRL_PRIO_START  = 2;

  // Index width for a requester count (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/count_job_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module count_job_sched_rr_arbiter
  import count_job_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  assign any = |req;

  // Scan requesters starting at ptr; the first hit is the winner.
  always_comb begin
    pick    = '0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IW'((int'(ptr) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found      = 1'b1;
        pick[w_cand] = 1'b1;
        idx          = w_cand;
      end
    end
  end

endmodule

// File: rtl/count_job_sched.sv
// Round-robin scheduler sharing one external W-bit counter among NREQ requesters.
module count_job_sched
  import count_job_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int LW   = LW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_load,
  input  logic [NREQ*LW-1:0] req_len,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      result,
  output logic              cnt_clear,
  output logic              cnt_preset,
  output logic              cnt_start,
  output logic [W-1:0]      cnt_inp,
  input  logic [W-1:0]      cnt_val
);

  localparam int IW = idx_width(NREQ);

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_ptr;
  logic [LW-1:0]   r_rem;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic            r_busy;
  logic [W-1:0]    r_result;
  logic            r_cnt_clear;
  logic            r_cnt_preset;
  logic            r_cnt_start;
  logic [W-1:0]    r_cnt_inp;

  logic [NREQ-1:0] w_pick;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [W-1:0]    w_load_arr [NREQ];
  logic [LW-1:0]   w_len_arr  [NREQ];
  logic [IW-1:0]   w_ptr_next;

  // Split the flat request buses into per-requester slices.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_load_arr[gi] = req_load[gi*W +: W];
    assign w_len_arr[gi]  = req_len[gi*LW +: LW];
  end

  count_job_sched_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req  (req),
    .ptr  (r_ptr),
    .pick (w_pick),
    .idx  (w_idx),
    .any  (w_any)
  );

  // Served requester hands priority to its neighbour.
  assign w_ptr_next = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;

  // Scheduler FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_ptr        <= '0;
      r_rem        <= '0;
      r_grant      <= '0;
      r_done       <= '0;
      r_busy       <= 1'b0;
      r_result     <= '0;
      r_cnt_clear  <= 1'b0;
      r_cnt_preset <= 1'b0;
      r_cnt_start  <= 1'b0;
      r_cnt_inp    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state      <= ST_LOAD;
            r_idx        <= w_idx;
            r_rem        <= w_len_arr[w_idx];
            r_cnt_inp    <= w_load_arr[w_idx];
            r_grant      <= w_pick;
            r_busy       <= 1'b1;
            r_cnt_preset <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_cnt_preset <= 1'b0;
          r_cnt_inp    <= '0;
          if (r_rem == '0) begin
            r_state     <= ST_DONE;
            r_done      <= r_grant;
            r_cnt_clear <= 1'b1;
          end else begin
            r_state     <= ST_RUN;
            r_cnt_start <= 1'b1;
          end
        end
        ST_RUN: begin
          r_rem <= r_rem - 1'b1;
          if (r_rem == LW'(1)) begin
            r_state     <= ST_DONE;
            r_cnt_start <= 1'b0;
            r_done      <= r_grant;
            r_cnt_clear <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_result    <= cnt_val;
          r_ptr       <= w_ptr_next;
          r_grant     <= '0;
          r_done      <= '0;
          r_busy      <= 1'b0;
          r_cnt_clear <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign busy       = r_busy;
  assign result     = r_result;
  assign cnt_clear  = r_cnt_clear;
  assign cnt_preset = r_cnt_preset;
  assign cnt_start  = r_cnt_start;
  assign cnt_inp    = r_cnt_inp;

endmodule

// File: tb/tb_count_job_sched.sv
// Scoreboard bench: round-robin job model feeds an expectation queue, a monitor checks DUT output.
module tb_count_job_sched;

  localparam int NREQ  = 4;
  localparam int W     = 3;
  localparam int LW    = 4;
  localparam int LIMIT = 3000;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*W-1:0]  req_load;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [W-1:0]       result;
  logic               cnt_clear;
  logic               cnt_preset;
  logic               cnt_start;
  logic [W-1:0]       cnt_inp;
  logic [W-1:0]       cnt_val = '0;

  typedef struct { int load; int len; } job_t;
  typedef struct { int idx; int load; int len; int result; bit chk_gap; } exp_t;

  job_t jq [NREQ][$];
  exp_t sb [$];
  int   m_ptr = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  count_job_sched #(.NREQ(NREQ), .W(W), .LW(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_load   (req_load),
    .req_len    (req_len),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .result     (result),
    .cnt_clear  (cnt_clear),
    .cnt_preset (cnt_preset),
    .cnt_start  (cnt_start),
    .cnt_inp    (cnt_inp),
    .cnt_val    (cnt_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared counter: clear > preset > start.
  always @(posedge clk) begin
    if (cnt_clear)       cnt_val <= '0;
    else if (cnt_preset) cnt_val <= cnt_inp;
    else if (cnt_start)  cnt_val <= cnt_val + 1'b1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: per-job cycle accounting, compared against the scoreboard head on done.
  int in_job = 0, cyc = 0, starts = 0, gap = 1000, pend = 0, pend_val = 0;
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      in_job = 0; pend = 0; gap = 1000; cyc = 0; starts = 0;
    end else begin
      if (pend != 0) begin
        chk("result", int'(result), pend_val);
        $display("job result=%0d", result);
        pend = 0;
      end
      if (busy) chk("ctrl_exclusive", (int'(cnt_clear) + int'(cnt_preset) + int'(cnt_start)) > 1 ? 1 : 0, 0);
      if (grant != '0) begin
        if (in_job == 0) begin
          int gidx;
          gidx = -1;
          for (int i = 0; i < NREQ; i++) if (grant[i]) gidx = i;
          in_job = 1; cyc = 0; starts = 0;
          chk("grant_onehot", $countones(grant), 1);
          chk("busy_in_job", int'(busy), 1);
          chk("preset_first", int'(cnt_preset), 1);
          if (sb.size() > 0) begin
            chk("grant_idx", gidx, sb[0].idx);
            chk("cnt_inp", int'(cnt_inp), sb[0].load);
            if (sb[0].chk_gap) chk("idle_gap", gap, 1);
          end
        end
        cyc++;
        if (cnt_start) starts++;
      end
      if (done != '0) begin
        if (sb.size() == 0) begin
          chk("done_without_job", int'(done), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("job done req=%0d load=%0d len=%0d cycles=%0d starts=%0d", e.idx, e.load, e.len, cyc, starts);
          chk("done_bit", int'(done), 1 << e.idx);
          chk("grant_at_done", int'(grant), 1 << e.idx);
          chk("job_cycles", cyc, e.len + 2);
          chk("start_cycles", starts, e.len);
          chk("clear_at_done", int'(cnt_clear), 1);
          pend = 1; pend_val = e.result;
        end
        in_job = 0; gap = 0;
      end else if (!busy) begin
        gap++;
      end
    end
  end

  task automatic set_slice(input int i, input int ld, input int ln);
    req_load[i*W +: W]  = W'(ld);
    req_len[i*LW +: LW] = LW'(ln);
  endtask

  // Model the service order from pending job counts, then act as the requesters.
  task automatic run_batch();
    int pos [NREQ];
    int total, p, guard;
    logic [NREQ-1:0] seen, drop;
    total = 0;
    for (int i = 0; i < NREQ; i++) begin pos[i] = 0; total += jq[i].size(); end
    p = m_ptr;
    for (int n = 0; n < total; n++) begin
      int pick;
      exp_t e;
      pick = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (p + k) % NREQ;
        if (pick < 0 && pos[j] < jq[j].size()) pick = j;
      end
      e.idx = pick;
      e.load = jq[pick][pos[pick]].load;
      e.len = jq[pick][pos[pick]].len;
      e.result = (e.load + e.len) % (1 << W);
      e.chk_gap = (n > 0);
      sb.push_back(e);
      pos[pick]++;
      p = (pick + 1) % NREQ;
    end
    m_ptr = p;

    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (jq[i].size() > 0) begin
        req[i] = 1'b1;
        set_slice(i, jq[i][0].load, jq[i][0].len);
      end
    end
    seen = '0; drop = '0; guard = 0;
    while ((sb.size() > 0 || busy) && guard < LIMIT) begin
      @(negedge clk);
      guard++;
      for (int i = 0; i < NREQ; i++) begin
        if (drop[i]) begin req[i] = 1'b0; drop[i] = 1'b0; end
        if (grant[i] && !seen[i]) begin
          seen[i] = 1'b1;
          void'(jq[i].pop_front());
          if (jq[i].size() > 0) set_slice(i, jq[i][0].load, jq[i][0].len);
          else begin
            drop[i] = 1'b1;
            set_slice(i, $urandom_range(0, 7), $urandom_range(0, 15));
          end
        end else if (!grant[i]) begin
          seen[i] = 1'b0;
        end
      end
    end
    chk("batch_in_budget", (guard < LIMIT) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_clear"}, int'(cnt_clear), 0);
    chk({tag, "_preset"}, int'(cnt_preset), 0);
    chk({tag, "_start"}, int'(cnt_start), 0);
    chk({tag, "_inp"}, int'(cnt_inp), 0);
  endtask

  initial begin
    req = '0; req_load = '0; req_len = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic, wrap and zero-length jobs.
    jq[0].push_back('{5, 2});  run_batch();
    jq[1].push_back('{6, 3});  run_batch();
    jq[3].push_back('{5, 0});  run_batch();

    // All four held, requester 0 re-queued: order 0,1,2,3,0.
    jq[0].push_back('{1, 4}); jq[1].push_back('{2, 1}); jq[2].push_back('{7, 9});
    jq[3].push_back('{0, 0}); jq[0].push_back('{3, 12});
    run_batch();

    // Reset in the middle of a long job.
    @(negedge clk);
    req[2] = 1'b1; set_slice(2, 3, 10);
    repeat (4) @(negedge clk);
    req[0] = 1'b1; set_slice(0, 1, 1);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    $display("reset asserted mid-job");
    @(negedge clk);
    #2 reset = 1'b1;
    sb.delete();
    m_ptr = 0;
    jq[0].push_back('{1, 1}); jq[2].push_back('{3, 10});
    run_batch();

    // Randomized batches.
    for (int b = 0; b < 30; b++) begin
      int tot;
      tot = 0;
      for (int i = 0; i < NREQ; i++) begin
        int nj;
        nj = $urandom_range(0, 2);
        for (int k = 0; k < nj; k++) begin
          job_t j;
          j.load = $urandom_range(0, 7);
          j.len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
          jq[i].push_back(j);
          tot++;
        end
      end
      if (tot > 0) run_batch();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
